// File: rtl/mask_loader.sv
`timescale 1ns/1ps
// Descriptor-driven loader for the shadow-mask stage: parses a header plus a
// row-major LUT stream and issues MODE/VMAX/HMAX/LUT commands, padding each row to 16.
module mask_loader (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        cfg_enable,
  input  logic        cfg_rotate,
  input  logic        cfg_2x,
  output logic        cmd_wr,
  output logic [15:0] cmd_in,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_MODE0, S_VMAXC, S_HMAXC, S_LUT, S_PAD, S_DRAIN, S_FINAL
  } state_t;

  function automatic logic [15:0] mode_cmd(input logic en, input logic rot, input logic x2);
    return {3'b000, 9'b0, en, rot, x2, 1'b0};
  endfunction

  function automatic logic [15:0] lut_cmd(input logic [10:0] entry);
    return {3'b011, 2'b00, entry};
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  h_q, h_d, v_q, v_d, vmax_q, vmax_d, hmax_q, hmax_d;
  logic        err_q, err_d, early_q, early_d;
  logic        cmd_wr_q, cmd_wr_d, busy_q, busy_d, done_q, done_d;
  logic [15:0] cmd_in_q, cmd_in_d;
  logic        cfg_en_q, cfg_en_d, cfg_rot_q, cfg_rot_d, cfg_x2_q, cfg_x2_d;

  logic accept_s, cfg_changed_s, row_end_s, last_row_s, final_word_s;
  logic [3:0] h_inc_s;
  logic unused_hdr_bits_s;

  assign ld_ready = (state_q == S_HDR) || (state_q == S_DRAIN) ||
                    ((state_q == S_LUT) && (h_q <= hmax_q));
  assign accept_s      = ld_valid & ld_ready;
  assign cfg_changed_s = (cfg_enable != cfg_en_q) || (cfg_rotate != cfg_rot_q) ||
                         (cfg_2x != cfg_x2_q);
  assign h_inc_s       = h_q + 4'd1;
  assign row_end_s     = (h_q == 4'hF);
  assign last_row_s    = (v_q == vmax_q);
  assign final_word_s  = (h_q == hmax_q) && last_row_s;
  assign unused_hdr_bits_s = ^ld_data[11:8];

  // Next-state and command generation; early_q marks a stream that ended too soon
  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    vmax_d   = vmax_q;
    hmax_d   = hmax_q;
    err_d    = err_q;
    early_d  = early_q;
    cmd_wr_d = 1'b0;
    cmd_in_d = cmd_in_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cfg_en_d  = cfg_en_q;
    cfg_rot_d = cfg_rot_q;
    cfg_x2_d  = cfg_x2_q;
    case (state_q)
      S_IDLE: begin
        if (ld_valid) begin
          state_d = S_HDR;
          err_d   = 1'b0;
          early_d = 1'b0;
          busy_d  = 1'b1;
        end else if (cfg_changed_s) begin
          cmd_wr_d  = 1'b1;
          cmd_in_d  = mode_cmd(cfg_enable, cfg_rotate, cfg_2x);
          cfg_en_d  = cfg_enable;
          cfg_rot_d = cfg_rotate;
          cfg_x2_d  = cfg_2x;
        end else begin
          cmd_wr_d = 1'b0;
        end
      end
      S_HDR: begin
        if (!accept_s) begin
          state_d = S_HDR;
        end else if (ld_data[15:12] != 4'h1) begin
          err_d   = 1'b1;
          state_d = ld_last ? S_FINAL : S_DRAIN;
        end else begin
          vmax_d  = ld_data[7:4];
          hmax_d  = ld_data[3:0];
          h_d     = 4'd0;
          v_d     = 4'd0;
          err_d   = err_q | ld_last;
          early_d = ld_last;
          state_d = S_MODE0;
        end
      end
      S_MODE0: begin
        cmd_wr_d = 1'b1;
        cmd_in_d = mode_cmd(1'b0, cfg_rotate, cfg_2x);
        state_d  = S_VMAXC;
      end
      S_VMAXC: begin
        cmd_wr_d = 1'b1;
        cmd_in_d = {3'b001, 9'b0, vmax_q};
        state_d  = S_HMAXC;
      end
      S_HMAXC: begin
        cmd_wr_d = 1'b1;
        cmd_in_d = {3'b010, 9'b0, hmax_q};
        state_d  = early_q ? S_PAD : S_LUT;
      end
      S_LUT: begin
        if (accept_s) begin
          cmd_wr_d = 1'b1;
          cmd_in_d = lut_cmd(ld_data[10:0]);
          h_d      = h_inc_s;
          v_d      = row_end_s ? v_q + 4'd1 : v_q;
          if (final_word_s) begin
            if (ld_last) begin
              state_d = row_end_s ? S_FINAL : S_PAD;
            end else begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else if (ld_last) begin
            err_d   = 1'b1;
            early_d = 1'b1;
            state_d = S_PAD;
          end else begin
            state_d = ((h_q == hmax_q) && !row_end_s) ? S_PAD : S_LUT;
          end
        end else begin
          state_d = S_LUT;
        end
      end
      S_PAD: begin
        cmd_wr_d = 1'b1;
        cmd_in_d = lut_cmd(11'd0);
        h_d      = h_inc_s;
        if (!row_end_s) begin
          state_d = S_PAD;
        end else if (last_row_s) begin
          state_d = S_FINAL;
        end else begin
          v_d     = v_q + 4'd1;
          state_d = early_q ? S_PAD : S_LUT;
        end
      end
      S_DRAIN: begin
        if (accept_s && ld_last) begin
          state_d = S_FINAL;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_FINAL: begin
        cmd_wr_d  = 1'b1;
        cmd_in_d  = mode_cmd(cfg_enable & ~err_q, cfg_rotate, cfg_2x);
        cfg_en_d  = cfg_enable;
        cfg_rot_d = cfg_rotate;
        cfg_x2_d  = cfg_2x;
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any load in flight
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= S_IDLE;
      h_q       <= 4'd0;
      v_q       <= 4'd0;
      vmax_q    <= 4'd0;
      hmax_q    <= 4'd0;
      err_q     <= 1'b0;
      early_q   <= 1'b0;
      cmd_wr_q  <= 1'b0;
      cmd_in_q  <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_en_q  <= cfg_enable;
      cfg_rot_q <= cfg_rotate;
      cfg_x2_q  <= cfg_2x;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      vmax_q    <= vmax_d;
      hmax_q    <= hmax_d;
      err_q     <= err_d;
      early_q   <= early_d;
      cmd_wr_q  <= cmd_wr_d;
      cmd_in_q  <= cmd_in_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_en_q  <= cfg_en_d;
      cfg_rot_q <= cfg_rot_d;
      cfg_x2_q  <= cfg_x2_d;
    end
  end

  assign cmd_wr = cmd_wr_q;
  assign cmd_in = cmd_in_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_mask_loader.sv
`timescale 1ns/1ps
// Scoreboard bench for mask_loader: directed loads push expected commands,
// a negedge monitor pops and compares every cmd_wr strobe.
module tb_mask_loader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        cfg_enable, cfg_rotate, cfg_2x;
  logic        cmd_wr;
  logic [15:0] cmd_in;
  logic        busy, done, err;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] exp_q[$];
  bit          abort    = 1'b0;
  int          lut_cnt  = 0;
  logic        prev_rdy = 1'b0;

  mask_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .cfg_enable(cfg_enable),
    .cfg_rotate(cfg_rotate), .cfg_2x(cfg_2x), .cmd_wr(cmd_wr), .cmd_in(cmd_in),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every strobe must match the head of the expected queue
  always @(negedge clk_sys) begin
    if (cmd_wr === 1'b1) begin
      if (cmd_in[15:13] == 3'b011) lut_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL cmd_unexpected: got %h expected none", cmd_in);
      end else begin
        check("cmd", 32'(cmd_in), 32'(exp_q.pop_front()));
      end
      if (cmd_in == 16'h6000) check("pad_ready_low", 32'(prev_rdy), 32'(1'b0));
    end
    prev_rdy = ld_ready;
  end

  task automatic send(input logic [15:0] w[$], input bit gap);
    bit acc;
    for (int i = 0; i < w.size(); i++) begin
      if (abort) break;
      if (gap) begin
        ld_valid = 1'b0;
        @(posedge clk_sys); #1;
      end
      ld_valid = 1'b1;
      ld_data  = w[i];
      ld_last  = (i == w.size() - 1);
      acc = 1'b0;
      for (int c = 0; c < 300 && !acc && !abort; c++) begin
        @(negedge clk_sys);
        acc = ld_ready && !abort;
        @(posedge clk_sys); #1;
      end
      if (!acc && !abort) begin
        n_checks++;
        $display("FAIL send_timeout: word %0d got not-accepted expected accepted", i);
        break;
      end
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_done(input bit exp_err, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 600 && !seen; c++) begin
      @(negedge clk_sys);
      if (done === 1'b1) seen = 1'b1;
    end
    check({name, "_done"}, 32'(seen), 32'(1'b1));
    check({name, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk_sys);
    check({name, "_busy_clear"}, 32'(busy), 32'(1'b0));
    check({name, "_done_pulse"}, 32'(done), 32'(1'b0));
    check({name, "_all_cmds"}, 32'(exp_q.size()), 32'(0));
  endtask

  // Header 0x1012 load: V=1, H=2, six entries, 13 pads per row
  task automatic push_good(input logic [15:0] mode0, input logic [15:0] fin);
    exp_q.push_back(mode0);
    exp_q.push_back(16'h2001);
    exp_q.push_back(16'h4002);
    for (int r = 0; r < 2; r++)
      for (int h = 0; h < 16; h++)
        exp_q.push_back((h < 3) ? 16'(16'h6700 + r * 3 + h + 1) : 16'h6000);
    exp_q.push_back(fin);
  endtask

  task automatic push_n(input logic [15:0] val, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(val);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] ws[$];
    int base;
    bit reached;
    reset = 1'b1; ld_valid = 1'b0; ld_data = 16'd0; ld_last = 1'b0;
    cfg_enable = 1'b1; cfg_rotate = 1'b0; cfg_2x = 1'b1;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_cmd_wr", 32'(cmd_wr), 32'(1'b0));
    check("rst_cmd_in", 32'(cmd_in), 32'(16'h0000));
    check("rst_ld_ready", 32'(ld_ready), 32'(1'b0));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_done", 32'(done), 32'(1'b0));
    check("rst_err", 32'(err), 32'(1'b0));
    @(posedge clk_sys); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk_sys); #1;

    // Nominal load
    ws = '{16'h1012, 16'h0701, 16'h0702, 16'h0703, 16'h0704, 16'h0705, 16'h0706};
    push_good(16'h0002, 16'h000A);
    send(ws, 1'b0);
    wait_done(1'b0, "good");

    // Bad version: drained, only the final MODE with en=0
    ws = '{16'h2000, 16'h0701, 16'h0702};
    exp_q.push_back(16'h0002);
    send(ws, 1'b0);
    wait_done(1'b1, "bad_ver");

    // ld_last on the header: full zero fill of row 0
    ws = '{16'h1000};
    exp_q.push_back(16'h0002); exp_q.push_back(16'h2000); exp_q.push_back(16'h4000);
    push_n(16'h6000, 16);
    exp_q.push_back(16'h0002);
    send(ws, 1'b0);
    wait_done(1'b1, "hdr_last");

    // ld_last on the second entry: rest of row 0 and all of row 1 zero filled
    ws = '{16'h1012, 16'h0701, 16'h0702};
    exp_q.push_back(16'h0002); exp_q.push_back(16'h2001); exp_q.push_back(16'h4002);
    exp_q.push_back(16'h6701); exp_q.push_back(16'h6702);
    push_n(16'h6000, 30);
    exp_q.push_back(16'h0002);
    send(ws, 1'b0);
    wait_done(1'b1, "early_last");

    // Final expected word without ld_last: remaining words drained
    ws = '{16'h1000, 16'hF123, 16'h0456};
    exp_q.push_back(16'h0002); exp_q.push_back(16'h2000); exp_q.push_back(16'h4000);
    exp_q.push_back(16'h6123); exp_q.push_back(16'h0002);
    send(ws, 1'b0);
    wait_done(1'b1, "missing_last");

    // Nominal load with ld_valid bubbles
    ws = '{16'h1012, 16'h0701, 16'h0702, 16'h0703, 16'h0704, 16'h0705, 16'h0706};
    push_good(16'h0002, 16'h000A);
    send(ws, 1'b1);
    wait_done(1'b0, "gappy");

    // cfg changes in IDLE
    @(negedge clk_sys);
    exp_q.push_back(16'h0000);
    cfg_enable = 1'b0; cfg_2x = 1'b0;
    repeat (3) @(negedge clk_sys);
    exp_q.push_back(16'h0004);
    cfg_rotate = 1'b1;
    @(negedge clk_sys);
    check("cfg_strobe", 32'(cmd_wr), 32'(1'b1));
    @(negedge clk_sys);
    check("cfg_single", 32'(cmd_wr), 32'(1'b0));
    exp_q.push_back(16'h000A);
    cfg_enable = 1'b1; cfg_rotate = 1'b0; cfg_2x = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("cfg_all_cmds", 32'(exp_q.size()), 32'(0));

    // Reset after the 5th LUT command
    ws = '{16'h1012, 16'h0701, 16'h0702, 16'h0703, 16'h0704, 16'h0705, 16'h0706};
    exp_q.push_back(16'h0002); exp_q.push_back(16'h2001); exp_q.push_back(16'h4002);
    exp_q.push_back(16'h6701); exp_q.push_back(16'h6702); exp_q.push_back(16'h6703);
    push_n(16'h6000, 2);
    base = lut_cnt;
    reached = 1'b0;
    abort = 1'b0;
    fork
      send(ws, 1'b0);
    join_none
    for (int c = 0; c < 300 && !reached; c++) begin
      @(negedge clk_sys); #1;
      if (lut_cnt - base >= 5) reached = 1'b1;
    end
    check("rst_mid_reached", 32'(reached), 32'(1'b1));
    abort = 1'b1; ld_valid = 1'b0; reset = 1'b1;
    @(negedge clk_sys);
    check("rst_mid_cmd_wr", 32'(cmd_wr), 32'(1'b0));
    check("rst_mid_busy", 32'(busy), 32'(1'b0));
    check("rst_mid_cmds", 32'(exp_q.size()), 32'(0));
    @(posedge clk_sys); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk_sys); #1;
    abort = 1'b0;

    push_good(16'h0002, 16'h000A);
    send(ws, 1'b0);
    wait_done(1'b0, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
